// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets two requesters share one
// external combinational 32-bit ALU. Only one operation is in flight at a
// time: accept (IDLE) -> capture ALU result (EXEC) -> hand back (RESP).
// DATA_WIDTH exists for interface clarity; the shared ALU is 32 bits wide.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic [3:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_reg;
    logic                  rr_reg;
    logic                  owner_reg;
    logic [3:0]            op_reg;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic [1:0]            resp_valid_reg;
    logic                  busy_reg;

    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            resp_ready;
    logic                  grant;
    logic                  accept;
    logic [3:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;

    assign req_valid  = {req1_valid, req0_valid};
    assign resp_ready = {resp1_ready, resp0_ready};

    // Grant: a lone valid requester wins outright; rr breaks ties.
    always_comb begin
        grant = req_valid[1];
        if (req_valid == 2'b11) begin
            grant = rr_reg;
        end
    end

    // Ready goes only to the granted, valid requester and only while idle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi]
                                   && (grant == 1'(gi));
        end
    endgenerate

    assign accept = |req_ready;
    assign sel_op = grant ? req1_op : req0_op;
    assign sel_a  = grant ? req1_a  : req0_a;
    assign sel_b  = grant ? req1_b  : req0_b;

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign resp0_valid = resp_valid_reg[0];
    assign resp1_valid = resp_valid_reg[1];
    assign resp_result = result_reg;
    assign busy        = busy_reg;

    // The ALU sees the held operands continuously, so they only move on accept.
    assign alu_op = op_reg;
    assign alu_a  = a_reg;
    assign alu_b  = b_reg;

    // Sequencer: accept, sample the ALU one cycle later, hold the result until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rr_reg         <= 1'b0;
            owner_reg      <= 1'b0;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            result_reg     <= '0;
            resp_valid_reg <= 2'b00;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= sel_op;
                        a_reg     <= sel_a;
                        b_reg     <= sel_b;
                        owner_reg <= grant;
                        rr_reg    <= ~grant;
                        busy_reg  <= 1'b1;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg                <= alu_result;
                    resp_valid_reg[owner_reg] <= 1'b1;
                    state_reg                 <= RESP;
                end
                RESP: begin
                    // Only the owner's ready can release the result.
                    if (resp_ready[owner_reg]) begin
                        resp_valid_reg <= 2'b00;
                        busy_reg       <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_reg <= 2'b00;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of operands and result; the shared ALU is 32 bits, so only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have ports req0_valid/req1_valid  input  1  requester i presents an operation.
REQ-005 The block SHALL have ports req0_ready/req1_ready  output  1  arbiter accepts requester i's operation this cycle.
REQ-006 The block SHALL have ports req0_op/req1_op  input  4  ALU opcode, using the shared ALU_* encoding.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  DATA_WIDTH  operands A and B.
REQ-008 The block SHALL have ports resp0_valid/resp1_valid  output  1  result for requester i is available.
REQ-009 The block SHALL have ports resp0_ready/resp1_ready  input  1  requester i consumes its result.
REQ-010 The block SHALL have port resp_result  output  DATA_WIDTH  registered result, shared by both requesters and qualified by respi_valid.
REQ-011 The block SHALL have ports alu_op (4), alu_a (DATA_WIDTH), alu_b (DATA_WIDTH)  output  drive the shared ALU inputs.
REQ-012 The block SHALL have port alu_result  input  DATA_WIDTH  combinational result from the shared ALU.
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement FSM states IDLE, EXEC and RESP, with exactly one state active at a time.
REQ-015 In IDLE, the block SHALL assert at most one reqi_ready, for the granted requester; grant = the only valid requester; if both are valid, grant = the requester selected by the round-robin pointer rr.
REQ-016 The block SHALL make the IDLE grant combinational from reqi_valid and rr only; reqi_ready SHALL NOT depend on respi_ready.
REQ-017 On reqi_valid && reqi_ready, the block SHALL capture op/a/b into holding registers, record owner = i, set rr = ~i, and go to EXEC.
REQ-018 In EXEC and RESP, the block SHALL deassert both reqi_ready.
REQ-019 The block SHALL drive alu_op/alu_a/alu_b from the holding registers at all times; they SHALL change only on an accept.
REQ-020 In EXEC, the block SHALL register alu_result into resp_result and go to RESP; EXEC SHALL last exactly 1 cycle.
REQ-021 In RESP, the block SHALL assert resp[owner]_valid and keep the other respi_valid low.
REQ-022 In RESP, the block SHALL hold resp_result and resp[owner]_valid stable until resp[owner]_ready is high.
REQ-023 On resp[owner]_valid && resp[owner]_ready, the block SHALL return to IDLE; the next accept is earliest in the following cycle.
REQ-024 Timing: accept at cycle N, resp valid at cycle N+2, minimum issue interval 3 cycles.
REQ-025 The block SHALL ignore resp_ready from the non-owner and resp_ready in IDLE/EXEC.
REQ-026 The block SHALL NOT interpret opcodes: unknown opcodes pass through, and the ALU's result (0 for undefined ops) is returned unchanged.
REQ-027 With both requesters valid continuously, grants SHALL alternate 0,1,0,1...; a lone requester SHALL be granted back-to-back regardless of rr.
REQ-028 Requester obligation: a requester SHALL hold reqi_op/a/b stable while reqi_valid && !reqi_ready, and SHALL NOT drop valid before acceptance; the arbiter is not required to tolerate violations.

Reset
REQ-029 When rst_n is low at a clock edge, state SHALL become IDLE and rr SHALL become 0 (requester 0 preferred).
REQ-030 Reset SHALL clear the holding registers and resp_result to 0, and owner to 0.
REQ-031 During and after reset, reqi_ready SHALL be combinational per REQ-015 from IDLE, while respi_valid=0 and busy=0.
REQ-032 Reset asserted in EXEC or RESP SHALL abort the operation: no respi_valid SHALL appear for it, and the result SHALL be discarded.

Verification
REQ-033 Single request: req0 op=ALU_ADD, a=5, b=7 at cycle 0 -> req0_ready=1 at cycle 0; resp0_valid=1 with resp_result=12 at cycle 2; resp1_valid=0 throughout.
REQ-034 Contention: both valid from reset, req0 = SUB 10-3, req1 = XOR 0xF0^0xFF, resp_ready tied high -> req0 granted first with result 7 at cycle 2; req1 granted at cycle 3 with result 0x0F at cycle 5.
REQ-035 Backpressure: resp1_ready held low 4 cycles in RESP -> resp1_valid and resp_result remain stable; req0_ready=0 while pending; return to IDLE the cycle after resp1_ready rises.
REQ-036 Fairness: both requesters valid for 8 operations -> grant order 0,1,0,1,0,1,0,1; lone req1 for 3 operations -> 1,1,1.
REQ-037 Reset mid-operation: rst_n low during EXEC of an SLL 1<<4 -> no respi_valid for it; after release, busy=0 and a new ADD 1+1 returns 2.
REQ-038 Shift/compare passthrough: SRA a=0x80000000, b=4 -> 0xF8000000, and an undefined opcode 4'hF -> result 0.
